// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin output mux.
package mux2_arb_pkg;

    // IDLE: output register empty; FULL: output register holds an unconsumed word.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

    // Requester identifiers, as seen on selOut and stored in lastGnt.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. Purely combinational; grants at most one
// requester, and only while en is high. On contention the requester that
// did not win last time is chosen.
import mux2_arb_pkg::*;

module rr_pick2 (
    input  logic reqA,
    input  logic reqB,
    input  logic lastGnt,
    input  logic en,
    output logic gntA,
    output logic gntB
);

    // Grant selection: single request wins outright, contention alternates.
    always_comb begin
        gntA = 1'b0;
        gntB = 1'b0;
        if (en) begin
            if (reqA && reqB) begin
                if (lastGnt == SRC_A) begin
                    gntB = 1'b1;
                end else begin
                    gntA = 1'b1;
                end
            end else if (reqA) begin
                gntA = 1'b1;
            end else if (reqB) begin
                gntB = 1'b1;
            end else begin
                gntA = 1'b0;
                gntB = 1'b0;
            end
        end else begin
            gntA = 1'b0;
            gntB = 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Shares one registered W-bit output between requesters A and B using
// req/gnt handshakes on the input side and valid/ready on the output side.
// A new word may be loaded in the same cycle the current one is accepted,
// so back-to-back traffic runs at one word per cycle.
import mux2_arb_pkg::*;

module mux2_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reqA,
    input  logic [W-1:0] dA,
    output logic         gntA,
    input  logic         reqB,
    input  logic [W-1:0] dB,
    output logic         gntB,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] muxOUT,
    output logic         selOut
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       last_gnt_r;
    logic       can_load_s;
    logic       pick_en_s;
    logic       gnt_any_s;

    // The output register is free when empty or when its word leaves this cycle.
    assign can_load_s = (state_r == IDLE) || outReady;
    // Grants are suppressed while reset is asserted so nothing is captured.
    assign pick_en_s  = can_load_s && !rst;
    assign gnt_any_s  = gntA || gntB;
    assign outValid   = (state_r == FULL);

    rr_pick2 u_pick (
        .reqA    (reqA),
        .reqB    (reqB),
        .lastGnt (last_gnt_r),
        .en      (pick_en_s),
        .gntA    (gntA),
        .gntB    (gntB)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: any grant fills the register; a free slot with no grant empties it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_any_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FULL: begin
                if (gnt_any_s) begin
                    state_nxt_s = FULL;
                end else if (outReady) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output word, its source and the round-robin history update only on a grant.
    // lastGnt resets to B so that A wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            muxOUT     <= {W{1'b0}};
            selOut     <= SRC_A;
            last_gnt_r <= SRC_B;
        end else if (gntA) begin
            muxOUT     <= dA;
            selOut     <= SRC_A;
            last_gnt_r <= SRC_A;
        end else if (gntB) begin
            muxOUT     <= dB;
            selOut     <= SRC_B;
            last_gnt_r <= SRC_B;
        end else begin
            muxOUT     <= muxOUT;
            selOut     <= selOut;
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter. A reference model predicts grants
// each cycle; every predicted grant pushes the expected word onto a
// scoreboard queue that is popped when the word should appear on muxOUT.
`timescale 1ns/1ps
module tb_mux2_rr_arbiter;

    localparam int W = 4;

    typedef struct packed {
        logic         sel;
        logic [W-1:0] data;
    } sb_t;

    logic         clk;
    logic         rst;
    logic         reqA;
    logic [W-1:0] dA;
    logic         gntA;
    logic         reqB;
    logic [W-1:0] dB;
    logic         gntB;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] muxOUT;
    logic         selOut;

    int checks_r;
    int failures_r;

    sb_t          sb_q[$];
    logic         full_m;
    logic         last_m;
    logic [W-1:0] mux_m;
    logic         sel_m;

    mux2_rr_arbiter #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .reqA     (reqA),
        .dA       (dA),
        .gntA     (gntA),
        .reqB     (reqB),
        .dB       (dB),
        .gntB     (gntB),
        .outValid (outValid),
        .outReady (outReady),
        .muxOUT   (muxOUT),
        .selOut   (selOut)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle away from the active edge.
    always @(negedge clk) begin
        logic exp_a;
        logic exp_b;
        logic can;
        sb_t  e;
        // Registered outputs reflect the previous edge.
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mux_m = e.data;
            sel_m = e.sel;
        end
        chk_eq("outValid", {31'd0, outValid}, {31'd0, full_m});
        chk_eq("muxOUT", {28'd0, muxOUT}, {28'd0, mux_m});
        chk_eq("selOut", {31'd0, selOut}, {31'd0, sel_m});
        // Grant prediction for the coming edge.
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (rst) begin
            full_m = 1'b0;
            last_m = 1'b1;
            mux_m  = 4'h0;
            sel_m  = 1'b0;
        end else begin
            can = !full_m || outReady;
            if (can) begin
                if (reqA && reqB) begin
                    exp_a = last_m;
                    exp_b = !last_m;
                end else begin
                    exp_a = reqA;
                    exp_b = reqB;
                end
            end
            if (exp_a) begin
                sb_q.push_back('{sel: 1'b0, data: dA});
                full_m = 1'b1;
                last_m = 1'b0;
            end else if (exp_b) begin
                sb_q.push_back('{sel: 1'b1, data: dB});
                full_m = 1'b1;
                last_m = 1'b1;
            end else if (can) begin
                full_m = 1'b0;
            end
        end
        chk_eq("gntA", {31'd0, gntA}, {31'd0, exp_a});
        chk_eq("gntB", {31'd0, gntB}, {31'd0, exp_b});
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        full_m     = 1'b0;
        last_m     = 1'b1;
        mux_m      = 4'h0;
        sel_m      = 1'b0;
        rst        = 1'b1;
        reqA       = 1'b1;
        reqB       = 1'b1;
        dA         = 4'h5;
        dB         = 4'hA;
        outReady   = 1'b1;

        // Reset with both requesting, then contention: A, B, A, B.
        tick(2);
        rst = 1'b0;
        tick(4);

        // Single requester A, then drain.
        reqB = 1'b0;
        reqA = 1'b1;
        dA   = 4'h5;
        tick(1);
        reqA = 1'b0;
        tick(2);

        // Backpressure: load A=0, stall three cycles with B waiting, then release.
        dA   = 4'h0;
        reqA = 1'b1;
        tick(1);
        reqA     = 1'b0;
        outReady = 1'b0;
        reqB     = 1'b1;
        dB       = 4'hF;
        tick(3);
        outReady = 1'b1;
        tick(1);
        reqB = 1'b0;
        tick(1);

        // Reset mid-transfer while holding B=A, with A waiting.
        dB   = 4'hA;
        reqB = 1'b1;
        tick(1);
        reqB     = 1'b0;
        outReady = 1'b0;
        reqA     = 1'b1;
        dA       = 4'h3;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        reqA = 1'b0;
        tick(1);

        // Request withdrawal while stalled.
        reqB = 1'b1;
        dB   = 4'h7;
        tick(1);
        reqB = 1'b0;
        tick(2);
        outReady = 1'b1;
        tick(3);

        @(negedge clk);
        #1;
        chk_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one registered 2:1 W-bit mux output between two requesters, A and B.
- Each requester uses a req/gnt handshake; the consumer side uses valid/ready.
- Round-robin arbitration prevents starvation. The output register holds the selected word until the consumer accepts it.
- Sits between two producer blocks and a single downstream consumer, replacing a free-running sel input with a sequenced one.

Parameters:
- W, 4, data width of dA, dB and muxOUT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- reqA  input  1  requester A has a word on dA; held high until gntA.
- dA  input  W  requester A data; stable while reqA is high.
- gntA  output  1  one-cycle pulse; dA is captured at this edge.
- reqB  input  1  requester B has a word on dB; held high until gntB.
- dB  input  W  requester B data; stable while reqB is high.
- gntB  output  1  one-cycle pulse; dB is captured at this edge.
- outValid  output  1  muxOUT holds an unconsumed word.
- outReady  input  1  consumer accepts muxOUT when outValid and outReady are both high.
- muxOUT  output  W  registered selected data.
- selOut  output  1  source of the current muxOUT: 0 = A, 1 = B.

Behaviour:
- Reset (rst high at a clk edge):
  - outValid=0, muxOUT=0, selOut=0, lastGnt=1 (so A wins the first contention).
  - FSM goes to IDLE. gntA/gntB are 0 while rst is high.
- Reset mid-operation: any pending word is dropped. A requester holding req simply re-arbitrates after reset.
- FSM states:
  - IDLE: outValid=0.
  - FULL: outValid=1.
- Load condition: canLoad = (state==IDLE) or (state==FULL and outReady).
- Grant logic (combinational, same cycle as canLoad):
  - If canLoad and exactly one req is high, grant that requester.
  - If both are high, grant the one not equal to lastGnt.
  - If neither is high, no grant.
  - gntA and gntB are never high together.
- On a grant edge:
  - muxOUT <= granted data; selOut <= granted id; lastGnt <= granted id.
  - State goes to FULL.
- On canLoad with no request:
  - From FULL with outReady: go to IDLE, outValid=0, muxOUT retains its last value.
  - From IDLE: stay in IDLE.
- FULL with outReady low: hold muxOUT and selOut; no grant; requests wait.
- Simultaneous accept and load: in FULL with outReady=1 and a pending request, the new word is loaded in the same cycle. outValid stays 1, giving back-to-back throughput of one word per cycle.
- Latency: a request granted in cycle N has its data on muxOUT, with outValid=1, from cycle N+1.
- Fairness: under continuous requests from both sides, grants alternate A, B, A, B, and so on.
- Single requester: that requester is granted every cycle it requests while the output can load.
- Handshake rules:
  - A requester drops req, or presents new data, only after seeing gnt.
  - Dropping req before gnt is legal and cancels the request (no grant is issued).
- Width: all data paths are exactly W bits; no extension or truncation.

Decomposition:
- Package mux2_arb_pkg:
  - typedef enum logic {IDLE, FULL} arb_state_t.
  - Localparams SRC_A=1'b0, SRC_B=1'b1.
- Sub-module rr_pick2 (combinational): inputs reqA, reqB, lastGnt, en; outputs gntA, gntB. Instantiated once.
- The top module holds the FSM, output register, selOut and lastGnt.

Test Plan:
- Reset check: hold rst for 2 cycles with reqA=reqB=1 -> gntA=gntB=0, outValid=0, muxOUT=0; the first post-reset grant is gntA.
- Single requester A: dA=4'h5, reqA=1, outReady=1 -> gntA pulses; next cycle muxOUT=4'h5, selOut=0, outValid=1; then drop reqA -> outValid returns to 0 one cycle after acceptance.
- Contention: dA=4'h5 and dB=4'hA, both held, outReady=1 -> grant sequence A, B, A, B; muxOUT sequence 5, A, 5, A with selOut 0, 1, 0, 1.
- Backpressure: outReady=0 after the first load of dA=4'h0 -> muxOUT stays 4'h0 and no gnt for 3 cycles while reqB=1 with dB=4'hF; raise outReady -> gntB in the same cycle, next cycle muxOUT=4'hF.
- Reset mid-transfer: assert rst while FULL with muxOUT=4'hA -> next cycle outValid=0, muxOUT=0, lastGnt=1; a waiting reqA with dA=4'h3 is granted on the first cycle after rst deasserts.
- Request withdrawal: reqB high for 1 cycle while FULL with outReady=0, then low -> no gntB issued; muxOUT unchanged.
